// File: rtl/wfg_drive_pkg.sv
// Shared types and constants for the waveform-generator SPI drive arbiter.
package wfg_drive_pkg;

    localparam int   NCH_MIN    = 2;
    localparam int   NCH_MAX    = 8;
    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_SEND = 2'd2
    } st_e;

    // Channel index reached by stepping 'off' places past 'base', modulo n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/wfg_rr_pick.sv
// Combinational grant picker: fixed priority (lowest index) or round-robin
// starting just after the last served channel.
module wfg_rr_pick
    import wfg_drive_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IW  = 1
) (
    input  logic [NCH-1:0] pending_i,
    input  logic [IW-1:0]  last_i,
    input  logic           mode_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  idx_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        if (mode_i == PRIO_RR) begin
            // Walk from the farthest offset down so the nearest hit wins.
            for (int off = NCH; off >= 1; off--) begin
                if (pending_i[wrap_idx(int'(last_i), off, NCH)]) begin
                    gnt_o = '0;
                    gnt_o[wrap_idx(int'(last_i), off, NCH)] = 1'b1;
                    idx_o = IW'(wrap_idx(int'(last_i), off, NCH));
                end
            end
        end else begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (pending_i[k]) begin
                    gnt_o    = '0;
                    gnt_o[k] = 1'b1;
                    idx_o    = IW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/wfg_drive_arb.sv
// Slot sequencer sharing the single SPI drive between stimulus channels:
// snapshot on sync, grant pending channels one at a time, forward each word.
module wfg_drive_arb
    import wfg_drive_pkg::*;
#(
    parameter  int NCH = 2,
    parameter  int DW  = 32,
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_en_i,
    input  logic              ctrl_prio_i,
    input  logic [NCH-1:0]    ch_mask_i,
    input  logic              sync_i,
    input  logic [NCH-1:0]    s_valid_i,
    input  logic [NCH*DW-1:0] s_data_i,
    output logic [NCH-1:0]    s_ready_o,
    output logic              m_valid_o,
    output logic [DW-1:0]     m_data_o,
    output logic [IW-1:0]     m_chan_o,
    input  logic              m_ready_i,
    output logic              busy_o,
    output logic              overrun_o,
    input  logic              ovr_clr_i
);

    if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_nch_chk
        $error("wfg_drive_arb: NCH out of range");
    end

    st_e            state_q, state_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [IW-1:0]  last_q, last_d;
    logic [IW-1:0]  chan_q, chan_d;
    logic [DW-1:0]  data_q, data_d;
    logic           ovr_q, ovr_d;

    logic [NCH-1:0] gnt;
    logic [IW-1:0]  gidx;
    logic [DW-1:0]  gdata;
    logic           gvalid;

    wfg_rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
        .pending_i (pend_q),
        .last_i    (last_q),
        .mode_i    (ctrl_prio_i),
        .gnt_o     (gnt),
        .idx_o     (gidx)
    );

    always_comb begin
        gdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt[k]) gdata = s_data_i[k*DW +: DW];
        end
    end

    assign gvalid = |(gnt & s_valid_i);

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        last_d    = last_q;
        chan_d    = chan_q;
        data_d    = data_q;
        s_ready_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (sync_i && ctrl_en_i) begin
                    pend_d  = s_valid_i & ch_mask_i;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!ctrl_en_i || pend_q == '0) begin
                    pend_d  = '0;
                    state_d = ST_IDLE;
                end else if (gvalid) begin
                    s_ready_o = gnt & s_valid_i;
                    data_d    = gdata;
                    chan_d    = gidx;
                    state_d   = ST_SEND;
                end else begin
                    // Channel dropped its sample since the snapshot: skip it.
                    pend_d = pend_q & ~gnt;
                end
            end
            ST_SEND: begin
                if (m_ready_i) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (chan_q == IW'(k)) pend_d[k] = 1'b0;
                    end
                    last_d  = chan_q;
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A new overrun outranks a coincident clear.
    always_comb begin
        ovr_d = ovr_q;
        if (sync_i && state_q != ST_IDLE) ovr_d = 1'b1;
        else if (ovr_clr_i)               ovr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            last_q  <= IW'(NCH - 1);
            chan_q  <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign m_valid_o = (state_q == ST_SEND);
    assign m_data_o  = data_q;
    assign m_chan_o  = chan_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign overrun_o = ovr_q;

endmodule

// File: doc/wfg_drive_arb.md
# wfg_drive_arb

Sequencer and arbiter that shares the single SPI drive (sclk/cs/sdo serializer) of the waveform generator between several stimulus channels. On every pattern-sync pulse it snapshots which channels hold a sample, then grants them one at a time. Each granted sample is forwarded as one 32-bit word to the SPI drive over a valid/ready handshake. It sits between the stimulus generators (sine, memory) and the SPI drive inside the user project; its control inputs come from Wishbone-mapped config registers.

## Interface
- `NCH`, default 2: number of stimulus channels, 2..8.
- `DW`, default 32: sample/word width.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ctrl_en_i`  in  1  arbiter enable.
- `ctrl_prio_i`  in  1  0 = round-robin, 1 = fixed priority (channel 0 highest).
- `ch_mask_i`  in  NCH  per-channel enable; sampled only at snapshot.
- `sync_i`  in  1  one-cycle slot-start pulse from the pattern timer.
- `s_valid_i`  in  NCH  channel has a sample.
- `s_data_i`  in  NCH*DW  channel samples, channel k at [k*DW +: DW].
- `s_ready_o`  out  NCH  one-hot transfer strobe to the channel.
- `m_valid_o`  out  1  word available to the SPI drive.
- `m_data_o`  out  DW  word to serialize.
- `m_chan_o`  out  max(1,$clog2(NCH))  channel index of `m_data_o`.
- `m_ready_i`  in  1  SPI drive accepts the word.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `overrun_o`  out  1  sticky flag: a slot was missed.
- `ovr_clr_i`  in  1  clears `overrun_o`.

## Operation
- The FSM has three states: IDLE, ARB and SEND.
- **IDLE**
  - On `sync_i & ctrl_en_i`: set `pending <= s_valid_i & ch_mask_i`, go to ARB.
  - Otherwise stay in IDLE.
- **ARB**
  - If `!ctrl_en_i` or `pending == 0`: clear `pending`, go to IDLE.
  - Otherwise compute grant g:
    - Fixed priority: lowest set bit of `pending`.
    - Round-robin: first set bit at or after `last+1`, searching modulo NCH.
  - If `s_valid_i[g]`: drive `s_ready_o[g]=1` combinationally this cycle, register `s_data_i[g]` and g into the output regs, then go to SEND.
  - If `s_valid_i[g]` is low: clear `pending[g]` and stay in ARB. The channel is skipped for this slot and no transfer happens.
- **SEND**
  - Hold `m_valid_o=1` with stable `m_data_o`/`m_chan_o` until `m_ready_i`.
  - On acceptance: clear `pending[g]`, set `last <= g`, go to ARB.
  - Once raised, `m_valid_o` is never withdrawn. `ctrl_en_i` falling takes effect at the next ARB.
- **Overrun**
  - `sync_i` in ARB or SEND sets `overrun_o` and is otherwise ignored; there is no re-snapshot.
  - If `ovr_clr_i` and a new overrun occur in the same cycle, set wins.
- Changes to `ch_mask_i` and `ctrl_prio_i` during a slot affect only the next snapshot or decision.
- `s_ready_o` is never asserted to a channel whose `s_valid_i` is low.

## Timing
- Reset values:
  - State IDLE, `pending=0`, `last=NCH-1` (so channel 0 wins first in round-robin).
  - `m_valid_o=0`, `m_data_o=0`, `m_chan_o=0`, `s_ready_o=0`, `busy_o=0`, `overrun_o=0`.
- Latency:
  - `sync_i` in cycle n: ARB in n+1, with the source transfer (`s_ready_o`) in n+1.
  - `m_valid_o` rises in n+2.
- Throughput: with `m_ready_i` held high, a word is accepted in n+2 and the next grant occurs in n+3. One word is delivered per 2 cycles.
- A slot with k granted channels is done in 2k+1 cycles after `sync_i`, assuming zero backpressure.
- Reset asserted mid-transfer drops `m_valid_o` immediately (async). The word in flight is lost, and the SPI drive must reset with it.

## Structure
- Package `wfg_drive_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_ARB`, `ST_SEND`);
  - the `PRIO_RR`/`PRIO_FIXED` constants;
  - the NCH limit constant.
- Sub-module `wfg_rr_pick` is a purely combinational picker. Inputs: `pending`, `last`, `mode`. Outputs: one-hot grant plus index. It is instantiated once.
- Everything else (FSM, `pending`/`last`, output regs, overrun flag) lives in `wfg_drive_arb`.

## Test plan
- **Single channel:** NCH=2, mask=01, ch0 holds 25094; pulse `sync_i`, `m_ready_i=1`.
  - Required: `s_ready_o[0]` 1 cycle after sync; `m_valid_o` 2 cycles after sync with `m_data_o=25094`, `m_chan_o=0`; `busy_o` low again by sync+4.
- **Round-robin:** mask=11, ch0=46345 and ch1=237050 both valid; three slots.
  - Required: slot 1 sends ch0 then ch1.
  - Then set `ctrl_prio_i=1`, ch1 only valid in slot 2, both in slot 3. Required: slot 3 sends ch0 (46345) first.
- **Backpressure:** hold `m_ready_i=0` for 10 cycles after `m_valid_o`.
  - Required: `m_data_o` stable, no second `s_ready_o` pulse; then the word is accepted on the first `m_ready_i=1`.
- **Overrun:** second `sync_i` while in SEND.
  - Required: `overrun_o=1` and the slot completes unchanged; `ovr_clr_i` clears it; `ovr_clr_i` coincident with a new overrun leaves it at 1.
- **Valid drop / disable:** ch1 `s_valid_i` deasserted before its grant, then `ctrl_en_i=0` during SEND.
  - Required: ch1 skipped with no `s_ready_o[1]`; the SEND word still completes, then IDLE with `pending=0`.
- **Async reset mid-SEND:** assert `rst_n` low.
  - Required: `m_valid_o=0` within the same cycle.
  - After release, the first round-robin grant goes to ch0.
